// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multiply/divide HI/LO unit.
//   - op encodings presented on the op port
//   - FSM state encodings
//   - divider iteration count helper
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    // state | meaning
    // IDLE  | waiting for an accepted start; MTHI/MTLO complete here
    // MUL   | shift-add multiply iterations
    // DIV   | restoring divide iterations, one quotient bit per cycle
    // FIX   | sign fix-up, done pulse, HI/LO written on exit
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    localparam int DIV_ITERS_DEFAULT = 32;

    // Radix-2 division retires one quotient bit per iteration.
    function automatic int div_iters(input int width);
        return width;
    endfunction

endpackage

// File: rtl/muldiv_hilo_unit_if.sv
// muldiv_hilo_unit_if: EX-stage issue/read bus of the multiply/divide unit.
//   master: EX stage / hazard unit (drives start, op, operands, cancel, rd_req, rd_sel)
//   slave : muldiv_hilo_unit (drives rd_data, busy, stall, done, div_by_zero, hi, lo)
interface muldiv_hilo_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             cancel;
    logic             rd_req;
    logic             rd_sel;
    logic [WIDTH-1:0] rd_data;
    logic             busy;
    logic             stall;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, cancel, rd_req, rd_sel,
        input  rd_data, busy, stall, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, cancel, rd_req, rd_sel,
        output rd_data, busy, stall, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_hilo_unit_div_iter.sv
// div_iter: one restoring-division step.
//   rem_in   : current partial remainder (WIDTH+1 bits, always < divisor)
//   next_bit : next dividend bit shifted in
//   divisor  : divisor magnitude
//   rem_out  : next partial remainder
//   q_bit    : quotient bit produced by this step
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        shifted = {rem_in, next_bit};
        diff    = shifted - {2'b00, divisor};
        // No borrow out of the top bit means the divisor fits: keep the difference.
        q_bit   = ~diff[WIDTH+1];
        rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
    end
endmodule

// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: iterative multiply/divide unit with HI/LO registers.
//   clk, rst : clock, synchronous active-high reset
//   bus      : muldiv_hilo_unit_if.slave (issue, cancel, HI/LO read, status)
// Multiply takes MUL_CYCLES+1 cycles, divide WIDTH+1 cycles, start edge to
// HI/LO visible. Operands are converted to magnitudes at acceptance and the
// sign is restored in FIX.
module muldiv_hilo_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    muldiv_hilo_unit_if.slave bus
);
    localparam int K     = WIDTH / MUL_CYCLES;
    localparam int CNT_W = $clog2(WIDTH);
    localparam int DIV_N = div_iters(WIDTH);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   opb;      // multiplier (shifted) or divisor (held)
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   quo;      // dividend bits out, quotient bits in
    logic               is_div, neg_q, neg_r, dbz;

    logic               accept, is_signed, sign_a, sign_b, b_zero;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] pp, prod;
    logic [WIDTH:0]     rem_nxt;
    logic               q_bit;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        accept    = bus.start && !bus.cancel && (state == ST_IDLE);
        is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        sign_a    = is_signed && bus.src_a[WIDTH-1];
        sign_b    = is_signed && bus.src_b[WIDTH-1];
        b_zero    = (bus.src_b == '0);
        mag_a     = sign_a ? -bus.src_a : bus.src_a;
        mag_b     = sign_b ? -bus.src_b : bus.src_b;
        pp        = mcand * {{(2*WIDTH-K){1'b0}}, opb[K-1:0]};
        prod      = neg_q ? -acc : acc;
        quo_fix   = neg_q ? -quo : quo;
        // Divide-by-zero leaves |dividend| in rem; re-applying the dividend
        // sign yields the raw src_a for HI.
        rem_fix   = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    end

    div_iter #(.WIDTH(WIDTH)) u_div_iter (
        .rem_in   (rem),
        .next_bit (quo[WIDTH-1]),
        .divisor  (opb),
        .rem_out  (rem_nxt),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            acc    <= '0;
            mcand  <= '0;
            opb    <= '0;
            rem    <= '0;
            quo    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dbz    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (bus.op)
                            OP_MTHI: hi_q <= bus.src_a;
                            OP_MTLO: lo_q <= bus.src_a;
                            OP_MULT, OP_MULTU: begin
                                acc    <= '0;
                                mcand  <= {{WIDTH{1'b0}}, mag_a};
                                opb    <= mag_b;
                                neg_q  <= sign_a ^ sign_b;
                                neg_r  <= 1'b0;
                                is_div <= 1'b0;
                                dbz    <= 1'b0;
                                cnt    <= CNT_W'(MUL_CYCLES - 1);
                                state  <= ST_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                rem    <= '0;
                                quo    <= mag_a;
                                opb    <= mag_b;
                                neg_q  <= (sign_a ^ sign_b) && !b_zero;
                                neg_r  <= sign_a;
                                is_div <= 1'b1;
                                dbz    <= b_zero;
                                cnt    <= CNT_W'(DIV_N - 1);
                                state  <= ST_DIV;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (bus.cancel) begin
                        state <= ST_IDLE;
                    end else begin
                        acc   <= acc + pp;
                        mcand <= mcand << K;
                        opb   <= opb >> K;
                        if (cnt == '0) state <= ST_FIX;
                        else           cnt   <= cnt - 1'b1;
                    end
                end
                ST_DIV: begin
                    if (bus.cancel) begin
                        state <= ST_IDLE;
                    end else begin
                        rem <= rem_nxt;
                        quo <= {quo[WIDTH-2:0], q_bit};
                        if (cnt == '0) state <= ST_FIX;
                        else           cnt   <= cnt - 1'b1;
                    end
                end
                ST_FIX: begin
                    state <= ST_IDLE;
                    if (!bus.cancel) begin
                        if (is_div) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end else begin
                            hi_q <= prod[2*WIDTH-1:WIDTH];
                            lo_q <= prod[WIDTH-1:0];
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy        = (state != ST_IDLE);
    assign bus.done        = (state == ST_FIX) && !bus.cancel;
    assign bus.div_by_zero = bus.done && dbz;
    assign bus.stall       = bus.busy && (bus.start || bus.rd_req);
    assign bus.rd_data     = bus.rd_sel ? lo_q : hi_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// tb_muldiv_hilo_unit: directed bench with a behavioural model of the
// multiply/divide unit (plain 64-bit arithmetic plus a latency countdown)
// checked every cycle, and literal expectations for the directed vectors.
module tb_muldiv_hilo_unit;
    import muldiv_pkg::*;

    localparam int W  = 32;
    localparam int MC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_hilo_unit_if #(.WIDTH(W)) bus ();

    muldiv_hilo_unit #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model
    int           m_left = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
    logic         r_dbz = 1'b0;

    task automatic model_issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint       sa, sb, sq, sr;
        logic [63:0]  p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
            OP_MULT, OP_MULTU: begin
                if (o == OP_MULT) p = 64'(sa * sb);
                else              p = {32'b0, a} * {32'b0, b};
                r_hi = p[63:32]; r_lo = p[31:0]; r_dbz = 1'b0;
                m_left = MC + 1;
            end
            OP_DIV, OP_DIVU: begin
                if (b == '0) begin
                    r_hi = a; r_lo = '1; r_dbz = 1'b1;
                end else if (o == OP_DIV) begin
                    sq = sa / sb; sr = sa % sb;
                    r_lo = sq[31:0]; r_hi = sr[31:0]; r_dbz = 1'b0;
                end else begin
                    r_lo = a / b; r_hi = a % b; r_dbz = 1'b0;
                end
                m_left = W + 1;
            end
            default: ;
        endcase
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0; m_hi = '0; m_lo = '0;
        end else if (m_left > 0) begin
            if (bus.cancel)       m_left = 0;
            else if (m_left == 1) begin m_hi = r_hi; m_lo = r_lo; m_left = 0; end
            else                  m_left--;
        end else if (bus.start && !bus.cancel) begin
            model_issue(bus.op, bus.src_a, bus.src_b);
        end
    end

    // Per-cycle compare against the model
    initial begin
        logic e_busy, e_done;
        @(posedge clk);
        forever begin
            @(negedge clk);
            #2;
            e_busy = (m_left > 0);
            e_done = (m_left == 1) && !bus.cancel;
            check("busy",    bus.busy,        e_busy);
            check("done",    bus.done,        e_done);
            check("dbz",     bus.div_by_zero, e_done && r_dbz);
            check("stall",   bus.stall,       e_busy && (bus.start || bus.rd_req));
            check("hi",      bus.hi,          m_hi);
            check("lo",      bus.lo,          m_lo);
            check("rd_data", bus.rd_data,     bus.rd_sel ? m_lo : m_hi);
        end
    end

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.src_a = a; bus.src_b = b;
        @(negedge clk);
        bus.start = 1'b0; bus.src_a = ~a; bus.src_b = ~b;
    endtask

    // Counts cycles after acceptance until done; bounded.
    task automatic wait_done(input string name, input int exp_cyc, input logic exp_dbz);
        int cyc;
        cyc = 1;
        #2;
        while (bus.done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            #2;
            cyc++;
        end
        check({name, "_latency"}, 64'(cyc), 64'(exp_cyc));
        check({name, "_dbz"}, bus.div_by_zero, exp_dbz);
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int exp_cyc,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input logic exp_dbz);
        issue(o, a, b);
        wait_done(name, exp_cyc, exp_dbz);
        @(negedge clk);
        #2;
        check({name, "_hi"}, bus.hi, exp_hi);
        check({name, "_lo"}, bus.lo, exp_lo);
    endtask

    initial begin
        bus.start = 1'b0; bus.op = '0; bus.src_a = '0; bus.src_b = '0;
        bus.cancel = 1'b0; bus.rd_req = 1'b0; bus.rd_sel = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2;
        check("reset_hi",   bus.hi,   0);
        check("reset_lo",   bus.lo,   0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);

        run_op("mult",  OP_MULT,  32'hFFFF_FFFE, 32'h3, MC + 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        run_op("multu", OP_MULTU, 32'hFFFF_FFFE, 32'h3, MC + 1, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0);
        run_op("multu_big", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC + 1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("divu",  OP_DIVU,  32'd100, 32'd7, W + 1, 32'd2, 32'd14, 1'b0);
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, W + 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_min", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, W + 1, 32'h0, 32'h8000_0000, 1'b0);
        run_op("divu_z", OP_DIVU, 32'd5, 32'd0, W + 1, 32'd5, 32'hFFFF_FFFF, 1'b1);
        run_op("div_z",  OP_DIV,  32'hFFFF_FFF0, 32'd0, W + 1, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);

        // Cancel mid-multiply leaves preloaded HI/LO untouched
        issue(OP_MTHI, 32'h11, 32'h0);
        issue(OP_MTLO, 32'h22, 32'h0);
        issue(OP_MULTU, 32'd7, 32'd9);
        @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        #2;
        check("cancel_busy", bus.busy, 0);
        check("cancel_hi",   bus.hi,   32'h11);
        check("cancel_lo",   bus.lo,   32'h22);
        repeat (6) @(negedge clk);

        // cancel in IDLE blocks acceptance
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MTHI; bus.src_a = 32'h99; bus.cancel = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.cancel = 1'b0;
        #2;
        check("cancel_idle_hi", bus.hi, 32'h11);

        // Read while busy stalls; new result visible after FIX; start during FIX waits
        issue(OP_MULT, 32'd6, 32'd7);
        bus.rd_req = 1'b1; bus.rd_sel = 1'b1;
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MULTU; bus.src_a = 32'd3; bus.src_b = 32'd5;
        #2;
        check("fix_stall", bus.stall, 1);
        check("fix_done",  bus.done,  1);
        check("fix_stale", bus.rd_data, 32'h22);
        @(negedge clk);
        #2;
        check("post_fix_rd",    bus.rd_data, 32'd42);
        check("post_fix_stall", bus.stall,   0);
        @(negedge clk);
        bus.start = 1'b0; bus.rd_req = 1'b0;
        wait_done("second", MC + 1, 1'b0);
        @(negedge clk);
        #2;
        check("second_lo", bus.lo, 32'd15);
        check("second_hi", bus.hi, 32'd0);

        // Reset in the middle of a divide
        issue(OP_DIVU, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("rst_mid_hi",   bus.hi,   0);
        check("rst_mid_lo",   bus.lo,   0);
        check("rst_mid_busy", bus.busy, 0);
        issue(OP_MTHI, 32'hABCD, 32'h0);
        #2;
        check("mthi_hi",   bus.hi,   32'hABCD);
        check("mthi_busy", bus.busy, 0);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
